// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU control encodings and default datapath widths
// Purpose: shared constants for the ALU issue stage and its forwarding mux.
// Ports: none (package).
package alu_pkg;

  localparam int ALU_WIDTH      = 32;
  localparam int ALU_REG_ADDR_W = 5;
  localparam int ALU_CTRL_W     = 4;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_ctrl_e;

endpackage

// File: rtl/alu_fwd_mux.sv
// rtl/alu_fwd_mux.sv - per-operand forwarding select (combinational)
// Purpose: picks the freshest value of one source register.
//   Priority: x0 -> 0, then EX/MEM result, then MEM/WB result, then register file.
//   With FWD_EN=0 the bypass inputs are ignored and only the x0 rule applies.
// Ports:
//   rs_i        source register index
//   rf_data_i   register-file read value
//   mem_wr_i    EX/MEM result will be written
//   mem_rd_i    EX/MEM destination index
//   mem_data_i  EX/MEM result
//   wb_wr_i     MEM/WB result will be written
//   wb_rd_i     MEM/WB destination index
//   wb_data_i   MEM/WB result
//   data_o      resolved operand
module alu_fwd_mux #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5,
  parameter bit FWD_EN     = 1'b1
) (
  input  logic [REG_ADDR_W-1:0] rs_i,
  input  logic [WIDTH-1:0]      rf_data_i,
  input  logic                  mem_wr_i,
  input  logic [REG_ADDR_W-1:0] mem_rd_i,
  input  logic [WIDTH-1:0]      mem_data_i,
  input  logic                  wb_wr_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  input  logic [WIDTH-1:0]      wb_data_i,
  output logic [WIDTH-1:0]      data_o
);

  always_comb begin
    data_o = rf_data_i;
    if (rs_i == '0) begin
      data_o = '0;
    end else if (FWD_EN && mem_wr_i && (mem_rd_i == rs_i)) begin
      // EX/MEM is younger than MEM/WB, so it wins when both match.
      data_o = mem_data_i;
    end else if (FWD_EN && wb_wr_i && (wb_rd_i == rs_i)) begin
      data_o = wb_data_i;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - ID/EX pipeline register feeding the ALU
// Purpose: captures a decoded op, resolves operand forwarding at capture time and
//   presents registered left/right/control to the ALU under a valid/ready handshake
//   with back-pressure and flush.
// Build option: ALU_ISSUE_FWD_EN enables EX/MEM and MEM/WB bypassing; when undefined the
//   fwd_* inputs are ignored (x0 still reads as zero).
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   flush                              squash held op and any op offered this cycle
//   in_valid / in_ready                upstream handshake (in_ready combinational)
//   in_rs1, in_rs2, in_rs1_data,
//   in_rs2_data, in_imm, in_use_imm,
//   in_control, in_rd, in_reg_write    decoded op fields
//   fwd_mem_*, fwd_wb_*                bypass sources from EX/MEM and MEM/WB
//   out_ready / out_valid              downstream handshake
//   left, right, control, out_rd,
//   out_reg_write                      registered op presented to the ALU
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int WIDTH      = ALU_WIDTH,
  parameter int REG_ADDR_W = ALU_REG_ADDR_W,
  parameter int CTRL_W     = ALU_CTRL_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rs1,
  input  logic [REG_ADDR_W-1:0] in_rs2,
  input  logic [WIDTH-1:0]      in_rs1_data,
  input  logic [WIDTH-1:0]      in_rs2_data,
  input  logic [WIDTH-1:0]      in_imm,
  input  logic                  in_use_imm,
  input  logic [CTRL_W-1:0]     in_control,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_reg_write,
  input  logic                  fwd_mem_wr,
  input  logic [REG_ADDR_W-1:0] fwd_mem_rd,
  input  logic [WIDTH-1:0]      fwd_mem_data,
  input  logic                  fwd_wb_wr,
  input  logic [REG_ADDR_W-1:0] fwd_wb_rd,
  input  logic [WIDTH-1:0]      fwd_wb_data,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      left,
  output logic [WIDTH-1:0]      right,
  output logic [CTRL_W-1:0]     control,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_reg_write
);

`ifdef ALU_ISSUE_FWD_EN
  localparam bit FwdEn = 1'b1;
`else
  localparam bit FwdEn = 1'b0;
`endif

  logic                  valid_q,     valid_d;
  logic [WIDTH-1:0]      left_q,      left_d;
  logic [WIDTH-1:0]      right_q,     right_d;
  logic [CTRL_W-1:0]     control_q,   control_d;
  logic [REG_ADDR_W-1:0] rd_q,        rd_d;
  logic                  reg_write_q, reg_write_d;

  logic [WIDTH-1:0] rs1_val;
  logic [WIDTH-1:0] rs2_val;
  logic             load;

  alu_fwd_mux #(
    .WIDTH      (WIDTH),
    .REG_ADDR_W (REG_ADDR_W),
    .FWD_EN     (FwdEn)
  ) u_fwd_rs1 (
    .rs_i       (in_rs1),
    .rf_data_i  (in_rs1_data),
    .mem_wr_i   (fwd_mem_wr),
    .mem_rd_i   (fwd_mem_rd),
    .mem_data_i (fwd_mem_data),
    .wb_wr_i    (fwd_wb_wr),
    .wb_rd_i    (fwd_wb_rd),
    .wb_data_i  (fwd_wb_data),
    .data_o     (rs1_val)
  );

  alu_fwd_mux #(
    .WIDTH      (WIDTH),
    .REG_ADDR_W (REG_ADDR_W),
    .FWD_EN     (FwdEn)
  ) u_fwd_rs2 (
    .rs_i       (in_rs2),
    .rf_data_i  (in_rs2_data),
    .mem_wr_i   (fwd_mem_wr),
    .mem_rd_i   (fwd_mem_rd),
    .mem_data_i (fwd_mem_data),
    .wb_wr_i    (fwd_wb_wr),
    .wb_rd_i    (fwd_wb_rd),
    .wb_data_i  (fwd_wb_data),
    .data_o     (rs2_val)
  );

  // Empty, or the held op leaves this cycle: a new op can take its place.
  assign in_ready = !valid_q || out_ready;
  assign load     = in_valid && in_ready;

  always_comb begin
    valid_d     = valid_q;
    left_d      = left_q;
    right_d     = right_q;
    control_d   = control_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    if (flush) begin
      // Offered op is dropped even if in_ready is high.
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
    end else if (load) begin
      valid_d     = 1'b1;
      left_d      = rs1_val;
      right_d     = in_use_imm ? in_imm : rs2_val;
      control_d   = in_control;
      rd_d        = in_rd;
      reg_write_d = in_reg_write;
    end else if (out_ready) begin
      // Drain without refill; data registers keep stale values.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      left_q      <= '0;
      right_q     <= '0;
      control_q   <= CTRL_W'(ALU_AND);
      rd_q        <= '0;
      reg_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      left_q      <= left_d;
      right_q     <= right_d;
      control_q   <= control_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
    end
  end

  assign out_valid     = valid_q;
  assign left          = left_q;
  assign right         = right_q;
  assign control       = control_q;
  assign out_rd        = rd_q;
  assign out_reg_write = reg_write_q && valid_q;

endmodule
